stream_minmax: RTL and testbench
================================

STREAM_MINMAX -- requirements
Module: stream_minmax

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits (2..32).
REQ-002 Parameter FRAME_LEN, default 16, maximum samples per frame (2..256).
REQ-003 Parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input sample valid.
REQ-008 in_ready  out  1  block accepts a sample this cycle.
REQ-009 in_data  in  WIDTH  sample value.
REQ-010 in_last  in  1  marks the final sample of a frame; sampled only with an accepted sample.
REQ-011 out_valid  out  1  frame result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_min  out  WIDTH  frame minimum.
REQ-014 out_max  out  WIDTH  frame maximum.
REQ-015 out_count  out  $clog2(FRAME_LEN+1)  number of samples in the frame.

Function
REQ-016 A sample SHALL be accepted on a rising clk edge when in_valid and in_ready are both 1.
REQ-017 The FSM SHALL have three states: IDLE (no sample held), ACC (frame open), HOLD (result presented).
REQ-018 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-019 IDLE, on accept: load min = max = in_data and count = 1; go to ACC, or to HOLD if in_last is 1.
REQ-020 ACC, on accept: update min/max with in_data and increment count; go to HOLD if in_last is 1 or the new count equals FRAME_LEN.
REQ-021 Comparisons SHALL follow SIGNED; on equal values the stored min/max SHALL be kept.
REQ-022 out_valid SHALL be 1 exactly when the state is HOLD, i.e. one cycle after the closing sample is accepted.
REQ-023 out_min, out_max and out_count SHALL be stable while out_valid is 1 and out_ready is 0.
REQ-024 HOLD, when out_ready is 1: go to IDLE; no sample is accepted in that cycle.
REQ-025 When FRAME_LEN is reached, an in_last of 0 on the closing sample SHALL be ignored; the next accepted sample starts a new frame.
REQ-026 in_valid with in_ready at 0 SHALL NOT change any state, and the held sample SHALL NOT be lost.
REQ-027 Outputs SHALL be driven directly from registers, with no combinational path from in_* to out_*.

Reset
REQ-028 While rst_n is 0: state = IDLE, in_ready = 0, out_valid = 0, out_min = out_max = 0, out_count = 0.
REQ-029 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result.

Configuration
REQ-031 Macro STREAM_MINMAX_INDEX_EN: when defined, add outputs out_min_idx and out_max_idx (width $clog2(FRAME_LEN) each). They give the 0-based position in the frame of the first occurrence of the min/max, reset to 0, and follow the rules in REQ-021 to REQ-023.
REQ-032 When STREAM_MINMAX_INDEX_EN is undefined, these ports and their registers SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033 WIDTH=8, SIGNED=0: frame 5,200,3,3(last) -> out_min=3, out_max=200, out_count=4, out_valid 1 cycle after the last accept; with INDEX_EN, min_idx=2 and max_idx=1.
REQ-034 SIGNED=1: frame 8'h80,8'h7F,8'h00(last) -> out_min=8'h80 (-128), out_max=8'h7F, out_count=3.
REQ-035 FRAME_LEN=4, in_last held 0: 8 samples 1..8 -> two results, (1,4,4) then (5,8,4).
REQ-036 out_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0, result stable, no sample consumed; when out_ready rises, next frame starts from the held sample.
REQ-037 Single-sample frame 42 with in_last=1 -> out_min=out_max=42, out_count=1.
REQ-038 rst_n pulsed low after 2 samples of a frame -> all outputs 0; next frame 9,1(last) gives min=1, max=9, count=2.

Source files
------------

// File: rtl/stream_minmax.sv
// Streaming frame reducer: tracks min, max and sample count per frame behind valid/ready handshakes.
// Optional macro STREAM_MINMAX_INDEX_EN adds first-occurrence positions of the min and max.
module stream_minmax #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int SIGNED    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_min,
    output logic [WIDTH-1:0]               out_max,
    output logic [$clog2(FRAME_LEN+1)-1:0] out_count
`ifdef STREAM_MINMAX_INDEX_EN
    ,
    output logic [$clog2(FRAME_LEN)-1:0]   out_min_idx,
    output logic [$clog2(FRAME_LEN)-1:0]   out_max_idx
`endif
);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_inc;
    logic             w_accept;
    logic             w_load;
    logic             w_upd_min;
    logic             w_upd_max;
`ifdef STREAM_MINMAX_INDEX_EN
    logic [IW-1:0]    r_min_idx;
    logic [IW-1:0]    r_max_idx;
`endif

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic lt;
        if (SIGNED != 32'sd0) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
        return lt;
    endfunction

    // Handshake decode and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = in_valid & r_in_ready;
        w_count_inc = r_count + CW'(1'b1);
        w_load      = w_accept & (r_state == S_IDLE);
        // strict compares so an equal value never displaces the stored extreme
        w_upd_min   = w_accept & less_than(in_data, r_min);
        w_upd_max   = w_accept & less_than(r_max, in_data);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? S_HOLD : S_ACC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC: begin
                if (w_accept && (in_last || (w_count_inc == CW'(FRAME_LEN)))) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_ACC;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered handshake flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_HOLD);
            r_out_valid <= (w_state_nxt == S_HOLD);
        end
    end

    // Frame accumulators; the pre-increment count is the position of the incoming sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min     <= {WIDTH{1'b0}};
            r_max     <= {WIDTH{1'b0}};
            r_count   <= {CW{1'b0}};
`ifdef STREAM_MINMAX_INDEX_EN
            r_min_idx <= {IW{1'b0}};
            r_max_idx <= {IW{1'b0}};
`endif
        end else if (w_load) begin
            r_min     <= in_data;
            r_max     <= in_data;
            r_count   <= CW'(1'b1);
`ifdef STREAM_MINMAX_INDEX_EN
            r_min_idx <= {IW{1'b0}};
            r_max_idx <= {IW{1'b0}};
`endif
        end else if (w_accept) begin
            r_count <= w_count_inc;
            if (w_upd_min) begin
                r_min     <= in_data;
`ifdef STREAM_MINMAX_INDEX_EN
                r_min_idx <= r_count[IW-1:0];
`endif
            end
            if (w_upd_max) begin
                r_max     <= in_data;
`ifdef STREAM_MINMAX_INDEX_EN
                r_max_idx <= r_count[IW-1:0];
`endif
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_min   = r_min;
    assign out_max   = r_max;
    assign out_count = r_count;
`ifdef STREAM_MINMAX_INDEX_EN
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;
`endif

endmodule

// File: tb/tb_stream_minmax.sv
// Directed scoreboard bench for stream_minmax: instance A is unsigned with FRAME_LEN=4,
// instance B is signed with FRAME_LEN=16.
module tb_stream_minmax;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid_t  [2];
    logic       in_last_t   [2];
    logic [7:0] in_data_t   [2];
    logic       out_ready_t [2];

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_min, a_out_max;
    logic [2:0] a_out_count;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_min, b_out_max;
    logic [4:0] b_out_count;
`ifdef STREAM_MINMAX_INDEX_EN
    logic [1:0] a_min_idx, a_max_idx;
    logic [3:0] b_min_idx, b_max_idx;
`endif

    stream_minmax #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_t[0]), .in_ready(a_in_ready), .in_data(in_data_t[0]), .in_last(in_last_t[0]),
        .out_valid(a_out_valid), .out_ready(out_ready_t[0]),
        .out_min(a_out_min), .out_max(a_out_max), .out_count(a_out_count)
`ifdef STREAM_MINMAX_INDEX_EN
        , .out_min_idx(a_min_idx), .out_max_idx(a_max_idx)
`endif
    );

    stream_minmax #(.WIDTH(8), .FRAME_LEN(16), .SIGNED(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_t[1]), .in_ready(b_in_ready), .in_data(in_data_t[1]), .in_last(in_last_t[1]),
        .out_valid(b_out_valid), .out_ready(out_ready_t[1]),
        .out_min(b_out_min), .out_max(b_out_max), .out_count(b_out_count)
`ifdef STREAM_MINMAX_INDEX_EN
        , .out_min_idx(b_min_idx), .out_max_idx(b_max_idx)
`endif
    );

    typedef struct packed {
        logic       v;
        logic       r;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] cnt;
        logic [7:0] mni;
        logic [7:0] mxi;
    } obs_t;

    typedef struct {
        int mn;
        int mx;
        int cnt;
        int mni;
        int mxi;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic obs_t obs(input int sel);
        obs_t o;
        o = '0;
        if (sel == 0) begin
            o.v   = a_out_valid;
            o.r   = a_in_ready;
            o.mn  = a_out_min;
            o.mx  = a_out_max;
            o.cnt = 8'(a_out_count);
`ifdef STREAM_MINMAX_INDEX_EN
            o.mni = 8'(a_min_idx);
            o.mxi = 8'(a_max_idx);
`endif
        end else begin
            o.v   = b_out_valid;
            o.r   = b_in_ready;
            o.mn  = b_out_min;
            o.mx  = b_out_max;
            o.cnt = 8'(b_out_count);
`ifdef STREAM_MINMAX_INDEX_EN
            o.mni = 8'(b_min_idx);
            o.mxi = 8'(b_max_idx);
`endif
        end
        return o;
    endfunction

    task automatic check(input string tag, input int obs_v, input int exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
        end
    endtask

    task automatic push(input int sel, input int mn, input int mx, input int cnt, input int mni, input int mxi);
        exp_t e;
        e.mn = mn; e.mx = mx; e.cnt = cnt; e.mni = mni; e.mxi = mxi;
        if (sel == 0) sb0.push_back(e);
        else          sb1.push_back(e);
    endtask

    // Drive one sample and return #1 after the edge that accepted it.
    task automatic send(input int sel, input logic [7:0] d, input logic l);
        obs_t o;
        bit   done;
        done = 1'b0;
        in_valid_t[sel] = 1'b1;
        in_data_t[sel]  = d;
        in_last_t[sel]  = l;
        for (int i = 0; i < 50 && !done; i++) begin
            o    = obs(sel);
            done = o.r;
            @(posedge clk); #1;
        end
        in_valid_t[sel] = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    // Wait for a result, compare it against the scoreboard head, then consume it.
    task automatic expect_res(input int sel, input string tag);
        obs_t o;
        exp_t e;
        bit   seen;
        seen = 1'b0;
        o    = obs(sel);
        for (int i = 0; i < 50 && !seen; i++) begin
            o = obs(sel);
            if (o.v) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_valid"}, int'(seen), 1);
        if (seen) begin
            if ((sel == 0 ? sb0.size() : sb1.size()) == 0) begin
                check({tag, "_sb_empty"}, 0, 1);
            end else begin
                e = (sel == 0) ? sb0.pop_front() : sb1.pop_front();
                check({tag, "_min"}, int'(o.mn), e.mn);
                check({tag, "_max"}, int'(o.mx), e.mx);
                check({tag, "_count"}, int'(o.cnt), e.cnt);
`ifdef STREAM_MINMAX_INDEX_EN
                check({tag, "_min_idx"}, int'(o.mni), e.mni);
                check({tag, "_max_idx"}, int'(o.mxi), e.mxi);
`endif
            end
            out_ready_t[sel] = 1'b1;
            @(posedge clk); #1;
            out_ready_t[sel] = 1'b0;
            o = obs(sel);
            check({tag, "_drop"}, int'(o.v), 0);
        end
    endtask

    initial begin
        obs_t o;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid_t[k] = 1'b0; in_last_t[k] = 1'b0; in_data_t[k] = 8'd0; out_ready_t[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        o = obs(0);
        check("rst_in_ready", int'(o.r), 0);
        check("rst_out_valid", int'(o.v), 0);
        check("rst_min", int'(o.mn), 0);
        check("rst_max", int'(o.mx), 0);
        check("rst_count", int'(o.cnt), 0);
        o = obs(1);
        check("rst_b_out_valid", int'(o.v), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        o = obs(0);
        check("post_rst_in_ready", int'(o.r), 1);

        // frame 5,200,3,3(last): equal 3 keeps first position
        push(0, 3, 200, 4, 2, 1);
        send(0, 8'd5, 1'b0);
        send(0, 8'd200, 1'b0);
        send(0, 8'd3, 1'b0);
        send(0, 8'd3, 1'b1);
        o = obs(0);
        check("basic_latency", int'(o.v), 1);
        expect_res(0, "basic");

        // FRAME_LEN=4 closes frames without in_last
        push(0, 1, 4, 4, 0, 3);
        push(0, 5, 8, 4, 0, 3);
        for (int s = 1; s <= 4; s++) send(0, 8'(s), 1'b0);
        expect_res(0, "auto1");
        for (int s = 5; s <= 8; s++) send(0, 8'(s), 1'b0);
        expect_res(0, "auto2");

        push(0, 42, 42, 1, 0, 0);
        send(0, 8'd42, 1'b1);
        expect_res(0, "single");

        // backpressure: result held, pending sample not consumed
        push(0, 10, 20, 2, 1, 0);
        send(0, 8'd20, 1'b0);
        send(0, 8'd10, 1'b1);
        in_valid_t[0] = 1'b1; in_data_t[0] = 8'd77; in_last_t[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            o = obs(0);
            check("bp_in_ready", int'(o.r), 0);
        end
        expect_res(0, "bp");
        push(0, 77, 77, 1, 0, 0);
        send(0, 8'd77, 1'b1);
        expect_res(0, "bp_next");

        // signed compare on instance B
        push(1, 8'h80, 8'h7F, 3, 0, 1);
        send(1, 8'h80, 1'b0);
        send(1, 8'h7F, 1'b0);
        send(1, 8'h00, 1'b1);
        expect_res(1, "signed");

        // reset mid-frame discards partial result
        send(0, 8'd50, 1'b0);
        send(0, 8'd60, 1'b0);
        rst_n = 1'b0;
        #1;
        o = obs(0);
        check("midrst_in_ready", int'(o.r), 0);
        check("midrst_valid", int'(o.v), 0);
        check("midrst_min", int'(o.mn), 0);
        check("midrst_max", int'(o.mx), 0);
        check("midrst_count", int'(o.cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(0, 1, 9, 2, 1, 0);
        send(0, 8'd9, 1'b0);
        send(0, 8'd1, 1'b1);
        expect_res(0, "after_rst");

        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
